// File: rtl/llc_pkg.sv
// Shared types for the LLC front end: source tags, arbiter states and the
// default payload width of the request slot.
package llc_pkg;

    typedef enum logic [1:0] {
        SRC_RST = 2'd0,
        SRC_RSP = 2'd1,
        SRC_REQ = 2'd2,
        SRC_DMA = 2'd3
    } llc_src_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } arb_state_t;

    localparam int REQ_W_DEF = 96;
    localparam int DMA_W_DEF = 160;
    localparam int RSP_W_DEF = 160;

    function automatic int llc_max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    localparam int PW = llc_max3(REQ_W_DEF, DMA_W_DEF, RSP_W_DEF);

endpackage

// File: rtl/llc_rr_pick2.sv
// Two-way round-robin picker between the CPU request and DMA channels.
// The preference flips only when a contested grant is actually taken.
module llc_rr_pick2 (
    input  logic clk,
    input  logic rst,
    input  logic req_elig,
    input  logic dma_elig,
    input  logic grant_en,
    output logic pick_dma
);

    logic rr_dma_q;
    logic rr_dma_d;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        pick_dma = dma_elig & (~req_elig | rr_dma_q);
        rr_dma_d = rr_dma_q;
        if (grant_en && req_elig && dma_elig) begin
            rr_dma_d = ~rr_dma_q;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_dma_q <= 1'b0;
        end else begin
            rr_dma_q <= rr_dma_d;
        end
    end

endmodule

// File: rtl/llc_input_arbiter.sv
// LLC front-end scheduler: arbitrates rst_tb, rsp, req and dma into one
// registered request slot consumed by the DECODE stage.
module llc_input_arbiter
    import llc_pkg::*;
#(
    parameter int REQ_W      = 96,
    parameter int DMA_W      = 160,
    parameter int RSP_W      = 160,
    parameter int STARVE_MAX = 15,
    localparam int PW        = llc_max3(REQ_W, DMA_W, RSP_W)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rst_tb_valid,
    input  logic             rst_tb_i,
    output logic             rst_tb_ready,
    input  logic             rsp_in_valid,
    input  logic [RSP_W-1:0] rsp_in_data,
    output logic             rsp_in_ready,
    input  logic             req_in_valid,
    input  logic [REQ_W-1:0] req_in_data,
    output logic             req_in_ready,
    input  logic             dma_in_valid,
    input  logic [DMA_W-1:0] dma_in_data,
    output logic             dma_in_ready,
    input  logic             req_stall,
    input  logic             dma_stall,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:0]       out_src,
    output logic [PW-1:0]    out_data,
    output logic             busy
);

    localparam int SW = $clog2(STARVE_MAX + 1);

    arb_state_t    state_q,      state_d;
    logic          out_valid_q,  out_valid_d;
    llc_src_t      out_src_q,    out_src_d;
    logic [PW-1:0] out_data_q,   out_data_d;
    logic [SW-1:0] starve_cnt_q, starve_cnt_d;

    logic          elig_req;
    logic          elig_dma;
    logic          rd_any;
    logic          starve_full;
    logic          pick_dma;
    logic          win_valid;
    logic          rd_win;
    llc_src_t      win_src;
    logic [PW-1:0] win_data;

    // Stall masks only matter while arbitrating; a held slot is never revoked.
    assign elig_req    = req_in_valid & ~req_stall;
    assign elig_dma    = dma_in_valid & ~dma_stall;
    assign rd_any      = elig_req | elig_dma;
    assign starve_full = (starve_cnt_q == SW'(STARVE_MAX));

    llc_rr_pick2 u_rr_pick2 (
        .clk      (clk),
        .rst      (rst),
        .req_elig (elig_req),
        .dma_elig (elig_dma),
        .grant_en (rd_win),
        .pick_dma (pick_dma)
    );

    always_comb begin
        win_valid = 1'b0;
        win_src   = SRC_RST;
        if (state_q == ST_IDLE) begin
            if (rst_tb_valid) begin
                win_valid = 1'b1;
                win_src   = SRC_RST;
            end else if (rsp_in_valid && !(starve_full && rd_any)) begin
                win_valid = 1'b1;
                win_src   = SRC_RSP;
            end else if (rd_any) begin
                win_valid = 1'b1;
                win_src   = pick_dma ? SRC_DMA : SRC_REQ;
            end
        end
    end

    assign rd_win = win_valid & ((win_src == SRC_REQ) | (win_src == SRC_DMA));

    always_comb begin
        win_data = '0;
        case (win_src)
            SRC_RST: win_data[0] = rst_tb_i;
            SRC_RSP: win_data = PW'(rsp_in_data);
            SRC_REQ: win_data = PW'(req_in_data);
            SRC_DMA: win_data = PW'(dma_in_data);
            default: win_data = '0;
        endcase
    end

    // Readies are forced low while reset is asserted so nothing is popped.
    assign rst_tb_ready = ~rst & win_valid & (win_src == SRC_RST);
    assign rsp_in_ready = ~rst & win_valid & (win_src == SRC_RSP);
    assign req_in_ready = ~rst & win_valid & (win_src == SRC_REQ);
    assign dma_in_ready = ~rst & win_valid & (win_src == SRC_DMA);

    always_comb begin
        state_d      = state_q;
        out_valid_d  = out_valid_q;
        out_src_d    = out_src_q;
        out_data_d   = out_data_q;
        starve_cnt_d = starve_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (win_valid) begin
                    state_d     = ST_HOLD;
                    out_valid_d = 1'b1;
                    out_src_d   = win_src;
                    out_data_d  = win_data;
                end
                if (rd_win || !rd_any) begin
                    starve_cnt_d = '0;
                end else if (win_valid && (win_src == SRC_RSP) && !starve_full) begin
                    starve_cnt_d = starve_cnt_q + 1'b1;
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b0;
                    out_src_d   = SRC_RST;
                    out_data_d  = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            out_valid_q  <= 1'b0;
            out_src_q    <= SRC_RST;
            out_data_q   <= '0;
            starve_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            out_valid_q  <= out_valid_d;
            out_src_q    <= out_src_d;
            out_data_q   <= out_data_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_src   = out_src_q;
    assign out_data  = out_data_q;
    assign busy      = out_valid_q | rst_tb_valid | rsp_in_valid | req_in_valid | dma_in_valid;

endmodule

// File: tb/tb_llc_input_arbiter.sv
// Self-checking bench for llc_input_arbiter: directed scenarios plus random
// traffic, all compared against a priority-list reference model.
module tb_llc_input_arbiter;

    localparam int REQ_W      = 96;
    localparam int DMA_W      = 160;
    localparam int RSP_W      = 160;
    localparam int STARVE_MAX = 3;
    localparam int PW         = 160;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             rst_tb_valid = 1'b0, rst_tb_i = 1'b0, rst_tb_ready;
    logic             rsp_in_valid = 1'b0, rsp_in_ready;
    logic [RSP_W-1:0] rsp_in_data = '0;
    logic             req_in_valid = 1'b0, req_in_ready;
    logic [REQ_W-1:0] req_in_data = '0;
    logic             dma_in_valid = 1'b0, dma_in_ready;
    logic [DMA_W-1:0] dma_in_data = '0;
    logic             req_stall = 1'b0, dma_stall = 1'b0;
    logic             out_valid, out_ready = 1'b1, busy;
    logic [1:0]       out_src;
    logic [PW-1:0]    out_data;

    always #5 clk = ~clk;

    llc_input_arbiter #(
        .REQ_W(REQ_W), .DMA_W(DMA_W), .RSP_W(RSP_W), .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk(clk), .rst(rst),
        .rst_tb_valid(rst_tb_valid), .rst_tb_i(rst_tb_i), .rst_tb_ready(rst_tb_ready),
        .rsp_in_valid(rsp_in_valid), .rsp_in_data(rsp_in_data), .rsp_in_ready(rsp_in_ready),
        .req_in_valid(req_in_valid), .req_in_data(req_in_data), .req_in_ready(req_in_ready),
        .dma_in_valid(dma_in_valid), .dma_in_data(dma_in_data), .dma_in_ready(dma_in_ready),
        .req_stall(req_stall), .dma_stall(dma_stall),
        .out_valid(out_valid), .out_ready(out_ready), .out_src(out_src),
        .out_data(out_data), .busy(busy)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: one slot, a starvation tally and a req/dma preference.
    bit            m_valid;
    int            m_src;
    logic [PW-1:0] m_data;
    int            m_starve;
    bit            m_rr_dma;
    bit            sticky[4];
    bit            prev_ov;
    int            got_q[$];
    int            exp_q[$];

    function automatic logic [PW-1:0] rand_wide();
        return {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    function automatic bit chan_valid(input int c);
        case (c)
            0:       return rst_tb_valid;
            1:       return rsp_in_valid;
            2:       return req_in_valid;
            default: return dma_in_valid;
        endcase
    endfunction

    task automatic set_chan(input int c, input bit v);
        case (c)
            0: begin rst_tb_valid = v; rst_tb_i = 1'($urandom_range(0, 1)); end
            1: begin rsp_in_valid = v; rsp_in_data = RSP_W'(rand_wide()); end
            2: begin req_in_valid = v; req_in_data = REQ_W'(rand_wide()); end
            default: begin dma_in_valid = v; dma_in_data = DMA_W'(rand_wide()); end
        endcase
    endtask

    // Returns the channel that should be accepted this cycle, or -1.
    function automatic int model_winner();
        bit e_req, e_dma;
        int rd;
        if (m_valid) return -1;
        e_req = req_in_valid && !req_stall;
        e_dma = dma_in_valid && !dma_stall;
        rd = -1;
        if (e_req && e_dma) rd = m_rr_dma ? 3 : 2;
        else if (e_req)     rd = 2;
        else if (e_dma)     rd = 3;
        if (rst_tb_valid) return 0;
        if (rsp_in_valid && !(m_starve == STARVE_MAX && rd >= 0)) return 1;
        return rd;
    endfunction

    function automatic logic [PW-1:0] model_payload(input int src);
        case (src)
            0:       return PW'(rst_tb_i);
            1:       return PW'(rsp_in_data);
            2:       return PW'(req_in_data);
            default: return PW'(dma_in_data);
        endcase
    endfunction

    // Entered at posedge+1 with inputs set; returns at the next posedge+1.
    task automatic cycle();
        int         w;
        bit         both, rd_any;
        logic [3:0] er;
        #3;
        w      = model_winner();
        both   = req_in_valid && !req_stall && dma_in_valid && !dma_stall;
        rd_any = (req_in_valid && !req_stall) || (dma_in_valid && !dma_stall);
        er     = '0;
        if (w >= 0) er[3-w] = 1'b1;
        check("out_valid", out_valid, m_valid);
        check("out_src", out_src, m_src);
        check("out_data", out_data, m_data);
        check("busy", busy, m_valid | rst_tb_valid | rsp_in_valid | req_in_valid | dma_in_valid);
        check("ready", {rst_tb_ready, rsp_in_ready, req_in_ready, dma_in_ready}, er);
        if (out_valid && !prev_ov) got_q.push_back(int'(out_src));
        prev_ov = out_valid;
        if (m_valid) begin
            if (out_ready) begin
                m_valid = 0; m_src = 0; m_data = '0;
            end
        end else if (w >= 0) begin
            m_valid = 1; m_src = w; m_data = model_payload(w);
            if (w >= 2) begin
                m_starve = 0;
                if (both) m_rr_dma = !m_rr_dma;
            end else if (!rd_any) begin
                m_starve = 0;
            end else if (w == 1) begin
                m_starve = (m_starve < STARVE_MAX) ? m_starve + 1 : STARVE_MAX;
            end
        end else begin
            m_starve = 0;
        end
        @(posedge clk);
        #1;
        if (w >= 0) set_chan(w, sticky[w]);
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    // Asynchronous reset landing mid-cycle; the slot must vanish at once.
    task automatic do_reset(input string tag);
        #2;
        rst = 1'b1;
        #1;
        check({tag, "_ov"}, out_valid, 1'b0);
        check({tag, "_rdy"}, {rst_tb_ready, rsp_in_ready, req_in_ready, dma_in_ready}, 4'b0);
        m_valid = 0; m_src = 0; m_data = '0; m_starve = 0; m_rr_dma = 0; prev_ov = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        got_q.delete();
    endtask

    task automatic clear_inputs();
        for (int c = 0; c < 4; c++) begin
            set_chan(c, 1'b0);
            sticky[c] = 0;
        end
        req_stall = 0; dma_stall = 0; out_ready = 1;
    endtask

    task automatic check_grants(input string tag);
        for (int i = 0; i < exp_q.size(); i++) begin
            check($sformatf("%s_g%0d", tag, i), (i < got_q.size()) ? got_q[i] : 255, exp_q[i]);
        end
    endtask

    initial begin
        for (int c = 0; c < 4; c++) set_chan(c, 1'b1);
        #3;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_src", out_src, 2'd0);
        check("rst_out_data", out_data, '0);
        check("rst_ready", {rst_tb_ready, rsp_in_ready, req_in_ready, dma_in_ready}, 4'b0);
        clear_inputs();
        m_valid = 0; m_src = 0; m_data = '0; m_starve = 0; m_rr_dma = 0; prev_ov = 0;
        @(posedge clk); #1;
        rst = 1'b0;

        // All four at once: strict priority with req before dma after reset.
        for (int c = 0; c < 4; c++) set_chan(c, 1'b1);
        run(10);
        exp_q = '{0, 1, 2, 3};
        check_grants("s1");

        clear_inputs();
        do_reset("s2r");
        sticky[2] = 1; sticky[3] = 1;
        set_chan(2, 1'b1); set_chan(3, 1'b1);
        run(16);
        exp_q = '{2, 3, 2, 3, 2, 3, 2, 3};
        check_grants("s2");

        clear_inputs();
        do_reset("s3r");
        sticky[1] = 1; sticky[2] = 1;
        set_chan(1, 1'b1); set_chan(2, 1'b1);
        run(10);
        exp_q = '{1, 1, 1, 2, 1};
        check_grants("s3");

        clear_inputs();
        do_reset("s4r");
        req_stall = 1;
        set_chan(2, 1'b1); set_chan(3, 1'b1);
        run(4);
        req_stall = 0;
        run(3);
        exp_q = '{3, 2};
        check_grants("s4");

        clear_inputs();
        do_reset("s5r");
        out_ready = 0;
        set_chan(2, 1'b1);
        run(1);
        set_chan(1, 1'b1);
        run(10);
        out_ready = 1;
        run(3);
        exp_q = '{2, 1};
        check_grants("s5");

        // Build up starvation, reset while a slot is held, then re-measure.
        clear_inputs();
        do_reset("s6r");
        sticky[1] = 1; sticky[2] = 1;
        set_chan(1, 1'b1); set_chan(2, 1'b1);
        run(3);
        check("s6_hold", out_valid, 1'b1);
        do_reset("s6");
        run(10);
        exp_q = '{1, 1, 1, 2};
        check_grants("s6");

        clear_inputs();
        do_reset("rnd_r");
        repeat (1500) begin
            cycle();
            for (int c = 0; c < 4; c++) begin
                if (!chan_valid(c)) begin
                    if ($urandom_range(0, (c == 0) ? 23 : 2) == 0) set_chan(c, 1'b1);
                end else if ($urandom_range(0, 15) == 0) begin
                    set_chan(c, 1'b0);
                end
            end
            req_stall = ($urandom_range(0, 3) == 0);
            dma_stall = ($urandom_range(0, 3) == 0);
            out_ready = ($urandom_range(0, 1) == 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
